quad_decoder: RTL and testbench

Quadrature-encoder front end producing single-cycle count enables and a direction level that drive the `EN` and `DNUP` inputs of the team's cascadable up/down counter chains directly, with `CAI` tied high on the first stage. It synchronises and deglitches the raw A/B phase inputs and tracks the Gray-code phase state. It emits one count pulse per qualified transition in x1, x2 or x4 resolution, and flags illegal double-bit jumps.

---
 rtl/quad_decoder.sv | 129 ++++++++++++
 tb/tb_quad_decoder.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/quad_decoder.sv
// Quadrature encoder front end: synchronises and deglitches A/B, tracks the Gray-code phase,
// and emits single-cycle count enables plus a direction level for up/down counter chains.
module quad_decoder #(
  parameter int FILT_LEN = 3,
  parameter int MODE     = 4
) (
  input  logic CLK,
  input  logic CS,
  input  logic A,
  input  logic B,
  input  logic ENA,
  input  logic ERR_CLR,
  output logic CNT_EN,
  output logic DNUP,
  output logic ERR,
  output logic VALID
);

  typedef enum logic [2:0] {
    P00  = 3'b000,
    P01  = 3'b001,
    P10  = 3'b010,
    P11  = 3'b011,
    INIT = 3'b100
  } state_t;

  localparam logic [3:0] FILT_CNT = 4'(FILT_LEN);

  logic [1:0] r_sync_p0, r_sync_p1, r_prev_p2;
  logic [3:0] r_cnt, w_cnt_nxt;
  logic       w_diff, w_accept, w_up;
  logic [1:0] w_phase;
  state_t     r_state, w_state_nxt;
  logic       r_cnt_en, r_dnup, r_err;
  logic       w_pulse, w_dnup_nxt, w_err_set;

  // Position along the up sequence P00 -> P10 -> P11 -> P01.
  function automatic logic [1:0] f_pos(input logic [1:0] ph);
    case (ph)
      2'b00:   f_pos = 2'd0;
      2'b10:   f_pos = 2'd1;
      2'b11:   f_pos = 2'd2;
      default: f_pos = 2'd3;
    endcase
  endfunction

  // Only called for single-bit changes, so "B low on both sides" means P00<->P10.
  function automatic logic f_qual(input logic [1:0] from, input logic [1:0] to);
    if (MODE == 1)      f_qual = ~from[0] & ~to[0];
    else if (MODE == 2) f_qual = from[1] ^ to[1];
    else                f_qual = 1'b1;
  endfunction

  function automatic state_t f_state(input logic [1:0] ph);
    case (ph)
      2'b00:   f_state = P00;
      2'b01:   f_state = P01;
      2'b10:   f_state = P10;
      default: f_state = P11;
    endcase
  endfunction

  // Stage p0/p1: two-flop synchroniser; p2: previous filter sample
  always_ff @(posedge CLK) begin
    if (CS) begin
      r_sync_p0 <= 2'b00;
      r_sync_p1 <= 2'b00;
      r_prev_p2 <= 2'b00;
      r_cnt     <= 4'd0;
    end else begin
      r_sync_p0 <= {A, B};
      r_sync_p1 <= r_sync_p0;
      r_prev_p2 <= r_sync_p1;
      r_cnt     <= w_accept ? 4'd0 : w_cnt_nxt;
    end
  end

  // The phase state doubles as the accepted value; INIT counts as "differs from anything".
  always_comb begin
    w_phase   = r_state[1:0];
    w_diff    = (r_state == INIT) || (r_sync_p1 != w_phase);
    w_cnt_nxt = 4'd1;
    if (!w_diff)
      w_cnt_nxt = 4'd0;
    else if ((r_cnt != 4'd0) && (r_sync_p1 == r_prev_p2))
      w_cnt_nxt = r_cnt + 4'd1;
    w_accept  = w_diff && (w_cnt_nxt == FILT_CNT);
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pulse     = 1'b0;
    w_dnup_nxt  = r_dnup;
    w_err_set   = 1'b0;
    w_up        = (f_pos(r_sync_p1) == (f_pos(w_phase) + 2'd1));
    if (w_accept) begin
      w_state_nxt = f_state(r_sync_p1);
      if (r_state != INIT) begin
        if ((r_sync_p1 ^ w_phase) == 2'b11) begin
          w_err_set = 1'b1;
        end else if (f_qual(w_phase, r_sync_p1)) begin
          w_dnup_nxt = ~w_up;
          w_pulse    = ENA;
        end
      end
    end
  end

  // Stage p3: phase state and registered outputs
  always_ff @(posedge CLK) begin
    if (CS) begin
      r_state  <= INIT;
      r_cnt_en <= 1'b0;
      r_dnup   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt_en <= w_pulse;
      r_dnup   <= w_dnup_nxt;
      r_err    <= w_err_set | (r_err & ~ERR_CLR);
    end
  end

  assign CNT_EN = r_cnt_en;
  assign DNUP   = r_dnup;
  assign ERR    = r_err;
  assign VALID  = (r_state != INIT);

endmodule

// File: tb/tb_quad_decoder.sv
// Bench for quad_decoder: x4, x2 and x1 instances share one stimulus and are checked every cycle
// against a window-based reference model, plus directed counter totals.
module tb_quad_decoder;

  localparam int FL = 3;

  logic       CLK = 1'b0;
  logic       CS, A, B, ENA, ERR_CLR;
  logic [2:0] cnt_en, dnup, err, valid;

  int n_cmp = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  quad_decoder #(.FILT_LEN(FL), .MODE(4)) u_x4 (
    .CLK(CLK), .CS(CS), .A(A), .B(B), .ENA(ENA), .ERR_CLR(ERR_CLR),
    .CNT_EN(cnt_en[0]), .DNUP(dnup[0]), .ERR(err[0]), .VALID(valid[0]));
  quad_decoder #(.FILT_LEN(FL), .MODE(2)) u_x2 (
    .CLK(CLK), .CS(CS), .A(A), .B(B), .ENA(ENA), .ERR_CLR(ERR_CLR),
    .CNT_EN(cnt_en[1]), .DNUP(dnup[1]), .ERR(err[1]), .VALID(valid[1]));
  quad_decoder #(.FILT_LEN(FL), .MODE(1)) u_x1 (
    .CLK(CLK), .CS(CS), .A(A), .B(B), .ENA(ENA), .ERR_CLR(ERR_CLR),
    .CNT_EN(cnt_en[2]), .DNUP(dnup[2]), .ERR(err[2]), .VALID(valid[2]));

  int         mode_of[3] = '{4, 2, 1};
  logic [1:0] fwd[4]     = '{2'b00, 2'b10, 2'b11, 2'b01};

  // Reference model: inputs seen per edge, filter samples, accepted value and expected outputs.
  logic [1:0] in_hist[$];
  logic [1:0] smp[$];
  logic       m_valid;
  logic [1:0] m_f;
  logic [2:0] m_cnt_en, m_dnup, m_err;

  // Downstream counter emulation driven by the DUT outputs.
  int net[3]      = '{0, 0, 0};
  int pls[3]      = '{0, 0, 0};
  int snap_net[3] = '{0, 0, 0};
  int snap_pls[3] = '{0, 0, 0};

  logic [1:0] v;
  int         h;

  function automatic int pos(input logic [1:0] p);
    case (p)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d, expected %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic model_edge();
    logic [1:0] s;
    bit         acc;
    bit         q;
    int         d;
    if (CS) begin
      in_hist.delete();
      smp.delete();
      m_valid  = 1'b0;
      m_f      = 2'b00;
      m_cnt_en = 3'b000;
      m_dnup   = 3'b000;
      m_err    = 3'b000;
    end else begin
      // The sample seen at this edge is the input level from two edges earlier.
      s = (in_hist.size() >= 2) ? in_hist[in_hist.size() - 2] : 2'b00;
      in_hist.push_back({A, B});
      if (in_hist.size() > 2) void'(in_hist.pop_front());
      smp.push_back(s);
      if (smp.size() > FL) void'(smp.pop_front());
      acc = (smp.size() == FL) && (!m_valid || (s != m_f));
      foreach (smp[i]) if (smp[i] != s) acc = 1'b0;
      m_cnt_en = 3'b000;
      m_err    = m_err & ~{3{ERR_CLR}};
      if (acc) begin
        if (m_valid) begin
          d = (pos(s) - pos(m_f) + 4) % 4;
          for (int m = 0; m < 3; m++) begin
            if (d == 2) begin
              m_err[m] = 1'b1;
            end else begin
              q = (mode_of[m] == 4) ||
                  (mode_of[m] == 2 && s[1] != m_f[1]) ||
                  (mode_of[m] == 1 && pos(s) <= 1 && pos(m_f) <= 1);
              if (q) begin
                m_dnup[m]   = (d == 3);
                m_cnt_en[m] = ENA;
              end
            end
          end
        end
        m_f     = s;
        m_valid = 1'b1;
      end
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
    for (int m = 0; m < 3; m++) begin
      chk($sformatf("cnt_en_x%0d", mode_of[m]), cnt_en[m], m_cnt_en[m]);
      chk($sformatf("dnup_x%0d", mode_of[m]), dnup[m], m_dnup[m]);
      chk($sformatf("err_x%0d", mode_of[m]), err[m], m_err[m]);
      chk($sformatf("valid_x%0d", mode_of[m]), valid[m], m_valid);
      if (cnt_en[m] === 1'b1) begin
        pls[m]++;
        net[m] += (dnup[m] === 1'b1) ? -1 : 1;
      end
    end
  endtask

  task automatic hold(input int n);
    repeat (n) tick();
  endtask

  task automatic snap();
    for (int m = 0; m < 3; m++) begin
      snap_net[m] = net[m];
      snap_pls[m] = pls[m];
    end
  endtask

  task automatic chk_delta(input string tag, input int m, input int exp_net, input int exp_pls);
    chk({tag, "_net"}, net[m] - snap_net[m], exp_net);
    chk({tag, "_pulses"}, pls[m] - snap_pls[m], exp_pls);
  endtask

  initial begin
    CS = 1'b1; A = 1'b0; B = 1'b0; ENA = 1'b1; ERR_CLR = 1'b0;
    hold(2);
    CS = 1'b0;

    // Acquisition from reset with A=B=0.
    hold(2);
    chk("acq_early_valid", valid[0], 1'b0);
    tick();
    chk("acq_valid", valid[0], 1'b1);
    chk("acq_cnt_en", cnt_en[0], 1'b0);
    chk("acq_dnup", dnup[0], 1'b0);
    hold(6);

    // Eight forward steps.
    snap();
    for (int i = 0; i < 8; i++) begin
      {A, B} = fwd[(i + 1) % 4];
      hold(10);
    end
    chk_delta("fwd_x4", 0, 8, 8);
    chk_delta("fwd_x2", 1, 4, 4);
    chk_delta("fwd_x1", 2, 2, 2);
    chk("fwd_dnup", dnup[0], 1'b0);

    // Eight reverse steps.
    snap();
    for (int i = 0; i < 8; i++) begin
      {A, B} = fwd[(7 - i) % 4];
      hold(10);
    end
    chk_delta("rev_x4", 0, -8, 8);
    chk_delta("rev_x2", 1, -4, 4);
    chk_delta("rev_x1", 2, -2, 2);
    chk("rev_dnup_x1", dnup[2], 1'b1);

    // Glitches on A: two cycles rejected, three cycles accepted (and the return accepted too).
    snap();
    {A, B} = 2'b10; hold(2);
    {A, B} = 2'b00; hold(10);
    chk_delta("glitch2_x4", 0, 0, 0);
    snap();
    {A, B} = 2'b10; hold(3);
    {A, B} = 2'b00; hold(10);
    chk_delta("glitch3_x4", 0, 0, 2);

    // Double-bit jump, then a forward step out of P11, then clear.
    snap();
    {A, B} = 2'b11; hold(10);
    chk("jump_err", err[0], 1'b1);
    chk_delta("jump_x4", 0, 0, 0);
    {A, B} = 2'b01; hold(10);
    chk_delta("after_jump_x4", 0, 1, 1);
    chk("after_jump_err", err[0], 1'b1);
    ERR_CLR = 1'b1; tick(); ERR_CLR = 1'b0;
    chk("err_clr", err[0], 1'b0);

    // Counting suppressed while tracking continues.
    snap();
    ENA = 1'b0;
    for (int i = 0; i < 4; i++) begin
      {A, B} = fwd[i];
      hold(10);
    end
    ENA = 1'b1;
    chk_delta("ena_off_x4", 0, 0, 0);
    chk("ena_off_dnup", dnup[0], 1'b0);

    // Reset lands one edge before a pending acceptance.
    snap();
    {A, B} = 2'b00; hold(3);
    CS = 1'b1; tick(); CS = 1'b0;
    chk("midrst_valid", valid[0], 1'b0);
    hold(10);
    chk_delta("midrst_x4", 0, 0, 0);

    // Random walk: any target level, random hold, ENA, ERR_CLR and occasional reset.
    for (int k = 0; k < 300; k++) begin
      v   = 2'($urandom_range(0, 3));
      h   = $urandom_range(1, 8);
      ENA = ($urandom_range(0, 3) != 0);
      {A, B} = v;
      repeat (h) begin
        ERR_CLR = ($urandom_range(0, 7) == 0);
        CS      = ($urandom_range(0, 199) == 0);
        tick();
      end
    end
    CS = 1'b0; ERR_CLR = 1'b0;
    hold(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
